// File: rtl/mmio_mixer_if.sv
// Bus bundle for the mmio_mixer slot.
// Carries the MMIO register port (chip select, strobes, address, write and
// read data) and the PCM streaming port (packed channel samples in, mixed
// sample out, each with a one-cycle valid).
// slave  : mixer side, master : host / sample source side.
interface mmio_mixer_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 16
);
   logic                       i_cs;
   logic                       i_write;
   logic                       i_read;
   logic [4:0]                 i_addr;
   logic [31:0]                i_write_data;
   logic [31:0]                o_read_data;
   logic [NUM_CH*DATA_W-1:0]   i_pcm;
   logic                       i_valid;
   logic [DATA_W-1:0]          o_pcm;
   logic                       o_valid;

   modport slave (
      input  i_cs, i_write, i_read, i_addr, i_write_data, i_pcm, i_valid,
      output o_read_data, o_pcm, o_valid
   );

   modport master (
      output i_cs, i_write, i_read, i_addr, i_write_data, i_pcm, i_valid,
      input  o_read_data, o_pcm, o_valid
   );
endinterface

// File: rtl/mmio_mixer.sv
// Multi-channel PCM mixer in one MMIO slot.
// Per sample tick it snapshots NUM_CH samples plus gains/mutes, runs a
// sequential multiply-accumulate one channel per clock, then rescales and
// saturates into one output sample. Software sees gains, enable, a peak
// meter, a saturating clip counter and a sticky overrun flag.
// Ports: i_clk, i_reset (sync, active high), bus (mmio_mixer_if.slave).
//
// state | meaning
// IDLE  | waiting for an accepted sample tick
// MAC   | accumulating product of channel ch, one per clock
// SAT   | rescale, clamp, register output and meters
module mmio_mixer #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 16,
   parameter int GAIN_W = 16
) (
   input  logic           i_clk,
   input  logic           i_reset,
   mmio_mixer_if.slave    bus
);
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PROD_W = DATA_W + GAIN_W + 1;
   localparam int ACC_W  = DATA_W + GAIN_W + $clog2(NUM_CH) + 1;
   localparam int SHIFT  = GAIN_W - 2;
   localparam logic [GAIN_W-1:0]       UNITY   = GAIN_W'(1) << SHIFT;
   localparam logic [CH_W-1:0]         LAST_CH = CH_W'(NUM_CH - 1);
   localparam logic signed [ACC_W-1:0] PCM_MAX = ACC_W'(2**(DATA_W-1) - 1);
   localparam logic signed [ACC_W-1:0] PCM_MIN = ~PCM_MAX;

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_SAT} state_t;

   state_t state_q, state_d;

   logic [GAIN_W-1:0]        gain_q [NUM_CH];
   logic [NUM_CH-1:0]        mute_q;
   logic                     enable_q;
   logic [DATA_W-2:0]        peak_q;
   logic [15:0]              clips_q;
   logic                     overrun_q;

   logic signed [DATA_W-1:0] snap_pcm [NUM_CH];
   logic [GAIN_W-1:0]        snap_gain [NUM_CH];
   logic [NUM_CH-1:0]        snap_mute;
   logic signed [ACC_W-1:0]  acc_q;
   logic [CH_W-1:0]          ch_q;
   logic [DATA_W-1:0]        pcm_q;
   logic                     valid_q;

   logic                     wr_en, wr_ctrl, clear, busy, accept;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  term, shifted;
   logic signed [DATA_W-1:0] sat_val;
   logic [DATA_W-1:0]        neg_val;
   logic [DATA_W-2:0]        mag;
   logic                     clip;
   logic                     unused_bits;

   assign unused_bits = ^{bus.i_read, bus.i_write_data};

   assign wr_en   = bus.i_cs & bus.i_write;
   assign wr_ctrl = wr_en && (bus.i_addr == 5'h10);
   assign clear   = wr_ctrl && bus.i_write_data[1];
   assign busy    = (state_q != S_IDLE);
   assign accept  = (state_q == S_IDLE) && bus.i_valid && enable_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_MAC;
         S_MAC:   if (ch_q == LAST_CH) state_d = S_SAT;
         S_SAT:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Gain is zero-extended so it multiplies as a non-negative value.
   always_comb begin
      prod    = $signed(snap_pcm[ch_q]) * $signed({1'b0, snap_gain[ch_q]});
      term    = snap_mute[ch_q] ? '0 : ACC_W'(prod);
      shifted = acc_q >>> SHIFT;
      clip    = 1'b0;
      if (shifted > PCM_MAX) begin
         sat_val = PCM_MAX[DATA_W-1:0];
         clip    = 1'b1;
      end else if (shifted < PCM_MIN) begin
         sat_val = PCM_MIN[DATA_W-1:0];
         clip    = 1'b1;
      end else begin
         sat_val = shifted[DATA_W-1:0];
      end
      neg_val = -sat_val;
      // Most-negative code has no positive twin; report full scale instead.
      if (!sat_val[DATA_W-1])                         mag = sat_val[DATA_W-2:0];
      else if (sat_val == PCM_MIN[DATA_W-1:0])        mag = '1;
      else                                            mag = neg_val[DATA_W-2:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int k = 0; k < NUM_CH; k++) begin
            gain_q[k]    <= UNITY;
            snap_pcm[k]  <= '0;
            snap_gain[k] <= '0;
         end
         mute_q    <= '0;
         snap_mute <= '0;
         enable_q  <= 1'b1;
         peak_q    <= '0;
         clips_q   <= '0;
         overrun_q <= 1'b0;
         acc_q     <= '0;
         ch_q      <= '0;
         pcm_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         if (wr_en && !bus.i_addr[4]) begin
            for (int k = 0; k < NUM_CH; k++) begin
               if (bus.i_addr[3:0] == 4'(k)) begin
                  gain_q[k] <= bus.i_write_data[GAIN_W-1:0];
                  mute_q[k] <= bus.i_write_data[16];
               end
            end
         end
         if (wr_ctrl) enable_q <= bus.i_write_data[0];

         if (accept) begin
            for (int k = 0; k < NUM_CH; k++) begin
               snap_pcm[k]  <= bus.i_pcm[k*DATA_W +: DATA_W];
               snap_gain[k] <= gain_q[k];
            end
            snap_mute <= mute_q;
            acc_q     <= '0;
            ch_q      <= '0;
         end

         if (state_q == S_MAC) begin
            acc_q <= acc_q + term;
            ch_q  <= ch_q + CH_W'(1);
         end

         valid_q <= 1'b0;
         if (state_q == S_SAT) begin
            pcm_q   <= sat_val;
            valid_q <= 1'b1;
            if (clip && clips_q != 16'hFFFF) clips_q <= clips_q + 16'd1;
            if (mag > peak_q) peak_q <= mag;
         end

         if (bus.i_valid && busy) overrun_q <= 1'b1;

         // Placed last so a clear beats a same-cycle meter update.
         if (clear) begin
            peak_q    <= '0;
            clips_q   <= '0;
            overrun_q <= 1'b0;
         end
      end
   end

   always_comb begin
      bus.o_read_data = '0;
      if (!bus.i_addr[4]) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (bus.i_addr[3:0] == 4'(k)) begin
               bus.o_read_data[GAIN_W-1:0] = gain_q[k];
               bus.o_read_data[16]         = mute_q[k];
            end
         end
      end else begin
         case (bus.i_addr[3:0])
            4'h0:    bus.o_read_data[0]            = enable_q;
            4'h1:    bus.o_read_data[DATA_W-2:0]   = peak_q;
            4'h2:    bus.o_read_data[15:0]         = clips_q;
            4'h3:    bus.o_read_data[1:0]          = {overrun_q, busy};
            default: bus.o_read_data               = '0;
         endcase
      end
   end

   assign bus.o_pcm   = pcm_q;
   assign bus.o_valid = valid_q;
endmodule

// File: tb/tb_mmio_mixer.sv
module tb_mmio_mixer;
   localparam int NUM_CH = 4;
   localparam int DATA_W = 16;

   typedef struct {
      logic [15:0] pcm;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   mmio_mixer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

   mmio_mixer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .GAIN_W(16)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // Monitor: every output pulse must match the head of the scoreboard in
   // both value and cycle; any pulse with nothing expected is an error.
   always @(negedge clk) begin
      if (bus.o_valid === 1'b1) begin
         exp_t e;
         checks = checks + 1;
         if (sb.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_valid cyc=%0d o_pcm=%0d", cyc, $signed(bus.o_pcm));
         end else begin
            e = sb.pop_front();
            if (bus.o_pcm !== e.pcm || cyc != e.cyc) begin
               errors = errors + 1;
               $display("FAIL mix_out got %0d @cyc %0d, want %0d @cyc %0d",
                        $signed(bus.o_pcm), cyc, $signed(e.pcm), e.cyc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
      bus.i_addr = a;
      bus.i_cs   = 1'b1;
      bus.i_read = 1'b1;
      #1;
      chk(name, bus.o_read_data, exp);
      bus.i_cs   = 1'b0;
      bus.i_read = 1'b0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.i_addr       = a;
      bus.i_write_data = d;
      bus.i_cs         = 1'b1;
      bus.i_write      = 1'b1;
      tick();
      bus.i_cs    = 1'b0;
      bus.i_write = 1'b0;
   endtask

   // Drives one tick; returns one ns after the sampling edge (cycle t+1).
   task automatic start_frame(input int c0, input int c1, input int c2, input int c3,
                              input int exp, input bit expect_out);
      logic [15:0] s0, s1, s2, s3, ev;
      s0 = 16'(c0); s1 = 16'(c1); s2 = 16'(c2); s3 = 16'(c3); ev = 16'(exp);
      @(negedge clk);
      bus.i_pcm   = {s3, s2, s1, s0};
      bus.i_valid = 1'b1;
      if (expect_out) sb.push_back('{pcm: ev, cyc: cyc + NUM_CH + 2});
      tick();
      bus.i_valid = 1'b0;
   endtask

   task automatic frame(input int c0, input int c1, input int c2, input int c3, input int exp);
      start_frame(c0, c1, c2, c3, exp, 1'b1);
      repeat (NUM_CH + 2) tick();
   endtask

   initial begin
      bus.i_cs = 0; bus.i_write = 0; bus.i_read = 0; bus.i_addr = '0;
      bus.i_write_data = '0; bus.i_pcm = '0; bus.i_valid = 0;
      repeat (3) tick();
      rst = 1'b0;

      chk("reset_o_valid", {31'd0, bus.o_valid}, 32'd0);
      chk("reset_o_pcm", {16'd0, bus.o_pcm}, 32'd0);
      rd(5'h00, 32'h0000_4000, "reset_gain0");
      rd(5'h03, 32'h0000_4000, "reset_gain3");
      rd(5'h10, 32'h1, "reset_ctrl");
      rd(5'h11, 32'h0, "reset_peak");
      rd(5'h12, 32'h0, "reset_clips");
      rd(5'h13, 32'h0, "reset_status");
      rd(5'h14, 32'h0, "unmapped");

      // Unity mix with busy window t+1..t+5 and idle in the output cycle.
      start_frame(1000, 2000, -500, 0, 2500, 1'b1);
      for (int i = 0; i < NUM_CH + 1; i++) begin
         rd(5'h13, 32'h1, "busy_during_frame");
         tick();
      end
      rd(5'h13, 32'h0, "busy_cleared_at_out");
      tick();
      rd(5'h11, 32'd2500, "peak_after_unity");

      // Saturation both ways.
      frame(30000, 30000, 30000, 30000, 32767);
      rd(5'h12, 32'd1, "clips_pos");
      rd(5'h11, 32'd32767, "peak_pos_sat");
      frame(-30000, -30000, -30000, -30000, -32768);
      rd(5'h12, 32'd2, "clips_neg");
      rd(5'h11, 32'd32767, "peak_neg_sat");
      wr(5'h10, 32'h3);
      rd(5'h11, 32'd0, "peak_cleared");
      rd(5'h12, 32'd0, "clips_cleared");
      rd(5'h10, 32'h1, "ctrl_clear_reads_0");

      // Gain, truncation toward -inf, mute.
      wr(5'h00, 32'h2000);
      rd(5'h00, 32'h2000, "gain0_readback");
      frame(1000, 0, 0, 0, 500);
      frame(-1, 0, 0, 0, -1);
      wr(5'h01, 32'h1_4000);
      rd(5'h01, 32'h1_4000, "gain1_mute_readback");
      frame(1000, 2000, 0, 0, 500);

      // Gain write at t+2 must not affect the frame in flight.
      start_frame(1000, 0, 0, 0, 500, 1'b1);
      tick();
      wr(5'h00, 32'h4000);
      repeat (4) tick();
      frame(1000, 0, 0, 0, 1000);
      repeat (3) tick();
      chk("o_pcm_hold", {16'd0, bus.o_pcm}, 32'd1000);
      chk("o_valid_low_between", {31'd0, bus.o_valid}, 32'd0);

      // Overrun: second tick at t+2 is dropped.
      start_frame(100, 0, 0, 0, 100, 1'b1);
      tick();
      @(negedge clk);
      bus.i_pcm   = {16'd7, 16'd7, 16'd7, 16'd7};
      bus.i_valid = 1'b1;
      tick();
      bus.i_valid = 1'b0;
      repeat (5) tick();
      rd(5'h13, 32'h2, "overrun_sticky");
      rd(5'h11, 32'd1000, "peak_running_max");
      wr(5'h10, 32'h3);
      rd(5'h13, 32'h0, "overrun_cleared");

      // Disabled: ticks ignored.
      wr(5'h10, 32'h0);
      rd(5'h10, 32'h0, "ctrl_disabled");
      start_frame(1234, 0, 0, 0, 0, 1'b0);
      rd(5'h13, 32'h0, "disabled_not_busy");
      repeat (8) tick();
      wr(5'h10, 32'h1);

      // Reset mid-frame aborts and restores defaults.
      wr(5'h00, 32'h1000);
      start_frame(1000, 0, 0, 0, 0, 1'b0);
      tick();
      @(negedge clk);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (6) tick();
      rd(5'h00, 32'h4000, "gain0_after_reset");
      rd(5'h01, 32'h4000, "gain1_after_reset");
      rd(5'h10, 32'h1, "ctrl_after_reset");
      rd(5'h13, 32'h0, "status_after_reset");
      frame(1000, 2000, -500, 0, 2500);

      repeat (4) tick();
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
